// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
//
// Inter-stage pipeline register for the pipelined core (F/D, D/E, E/M, M/W).
// Moves an opaque payload bundle between stages with a valid/ready handshake.
//
// SKID=0 is a single register. in_ready is combinational in this mode.
// SKID=1 adds a second (skid) entry, so in_ready comes straight from a flop.
//
// A synchronous flush kills every held beat and any beat offered that cycle.
// A saturating counter records the stall cycles for perf monitoring.
//
// Ports
//   clk           clock; all state updates on posedge
//   rst_n         synchronous, active-low reset (priority over flush)
//   flush         synchronous kill of all held and incoming beats
//   in_valid      upstream beat valid
//   in_ready      stage can accept a beat this cycle
//   in_payload    upstream bundle
//   out_valid     downstream beat valid (registered, == occupancy != 0)
//   out_ready     downstream accepts this cycle (low = stall)
//   out_payload   bundle presented downstream (registered main entry)
//   occupancy     held beats: 0..1 (SKID=0), 0..2 (SKID=1)
//   stall_cycles  saturating count of cycles with out_valid && !out_ready
// ---------------------------------------------------------------------------
module pipe_stage_elastic #(
   parameter int PAYLOAD_WIDTH   = 76,
   parameter bit SKID            = 1'b1,
   parameter bit CLEAR_ON_FLUSH  = 1'b1,
   parameter int STALL_CNT_WIDTH = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PAYLOAD_WIDTH-1:0]   in_payload,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PAYLOAD_WIDTH-1:0]   out_payload,
   output logic [1:0]                 occupancy,
   output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

   // Occupancy state. In SKID=0 mode, ONE is the FULL state and TWO is never reached.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_e;

   localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

   occ_e                       state_q,    state_d;
   logic [PAYLOAD_WIDTH-1:0]   main_q,     main_d;
   logic [PAYLOAD_WIDTH-1:0]   skid_q,     skid_d;
   logic                       in_ready_q, in_ready_d;
   logic [STALL_CNT_WIDTH-1:0] stall_q,    stall_d;

   logic in_fire;
   logic out_fire;

   assign out_valid    = (state_q != EMPTY);
   assign out_payload  = main_q;
   assign occupancy    = state_q;
   assign stall_cycles = stall_q;

   // Single-register mode can refill in the same cycle it drains.
   // That makes in_ready depend on out_ready combinationally.
   assign in_ready = SKID ? in_ready_q : (out_ready || !out_valid);

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   always_comb begin
      // NOTE: every signal written here gets a default first.
      // Otherwise a path that skips an assignment would infer a latch.
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      stall_d = stall_q;

      // The counter saturates at all-ones and is untouched by flush.
      if (out_valid && !out_ready && (stall_q != '1)) begin
         stall_d = stall_q + STALL_ONE;
      end

      if (flush) begin
         // A beat handshaked in this cycle is dropped.
         // An out-transfer in this cycle has already been delivered.
         state_d = EMPTY;
         if (CLEAR_ON_FLUSH) begin
            main_d = '0;
            skid_d = '0;
         end
      end else if (!SKID) begin
         if (in_fire) begin
            state_d = ONE;
            main_d  = in_payload;
         end else if (out_fire) begin
            state_d = EMPTY;
         end
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = ONE;
                  main_d  = in_payload;
               end
            end
            ONE: begin
               if (in_fire && out_fire) begin
                  main_d = in_payload;
               end else if (in_fire) begin
                  state_d = TWO;
                  skid_d  = in_payload;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               // in_ready is low here, so only the drain side can move.
               if (out_fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end

      in_ready_d = (state_d != TWO);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments.
      // All flops then sample the pre-edge values of the _d terms.
      if (!rst_n) begin
         state_q    <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
         stall_q    <= '0;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
         stall_q    <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Directed bench for pipe_stage_elastic. It uses two instances:
//   dut_a : SKID=1, CLEAR_ON_FLUSH=1, STALL_CNT_WIDTH=4 (stream, skid, flush,
//           stall saturation, reset mid-operation)
//   dut_b : SKID=0, CLEAR_ON_FLUSH=0, PAYLOAD_WIDTH=8 (bubble handling,
//           combinational ready, stale payload kept on flush)
//
// Inputs change 1 time unit after posedge.
// Outputs are checked after that settle time, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

   localparam int AW = 76;
   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst_n;

   logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [AW-1:0] a_in_payload, a_out_payload;
   logic [1:0]    a_occ;
   logic [3:0]    a_stall;

   logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [BW-1:0] b_in_payload, b_out_payload;
   logic [1:0]    b_occ;
   logic [15:0]   b_stall;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(
      .PAYLOAD_WIDTH(AW), .SKID(1'b1), .CLEAR_ON_FLUSH(1'b1), .STALL_CNT_WIDTH(4)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_payload(a_in_payload),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_payload(a_out_payload),
      .occupancy(a_occ), .stall_cycles(a_stall)
   );

   pipe_stage_elastic #(
      .PAYLOAD_WIDTH(BW), .SKID(1'b0), .CLEAR_ON_FLUSH(1'b0), .STALL_CNT_WIDTH(16)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_payload(b_in_payload),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_payload(b_out_payload),
      .occupancy(b_occ), .stall_cycles(b_stall)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Snapshot of dut_a outputs against hand-computed values.
   task automatic check_a(input string tag, input logic v, input logic [1:0] occ,
                          input logic rdy, input logic [AW-1:0] pl);
      check({tag, ".out_valid"}, a_out_valid, v);
      check({tag, ".occupancy"}, a_occ, occ);
      check({tag, ".in_ready"},  a_in_ready, rdy);
      if (v) check({tag, ".out_payload"}, a_out_payload, pl);
   endtask

   initial begin
      rst_n        = 1'b0;
      a_flush      = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_payload = '0;
      b_flush      = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_payload = '0;

      // Reset state
      step(); step();
      rst_n = 1'b1;
      check_a("rst", 1'b0, 2'd0, 1'b1, '0);
      check("rst.payload", a_out_payload, 0);
      check("rst.stall",   a_stall, 0);
      check("rst.b_valid", b_out_valid, 0);
      check("rst.b_occ",   b_occ, 0);

      // 1. Streaming: each beat appears one cycle after acceptance.
      a_out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         a_in_valid   = 1'b1;
         a_in_payload = AW'(i);
         step();
         check_a($sformatf("stream%0d", i), 1'b1, 2'd1, 1'b1, AW'(i));
      end
      a_in_valid = 1'b0;
      step();
      check_a("stream.drain", 1'b0, 2'd0, 1'b1, '0);
      check("stream.stall", a_stall, 0);

      // 2. Backpressure into the skid entry.
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_payload = AW'('hA);
      step();
      check_a("bp.A", 1'b1, 2'd1, 1'b1, AW'('hA));
      a_in_payload = AW'('hB);
      step();
      check_a("bp.AB", 1'b1, 2'd2, 1'b0, AW'('hA));
      a_in_payload = AW'('hD);            // offered while not ready: must be ignored
      step();
      check_a("bp.hold", 1'b1, 2'd2, 1'b0, AW'('hA));
      check("bp.stall", a_stall, 2);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      step();                             // A leaves, B moves to main
      check_a("bp.B", 1'b1, 2'd1, 1'b1, AW'('hB));
      step();                             // B leaves
      check_a("bp.empty", 1'b0, 2'd0, 1'b1, '0);
      check("bp.stall2", a_stall, 2);

      // 3. Flush with two held beats and a new beat offered.
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_payload = AW'('h1A);
      step();
      a_in_payload = AW'('h1B);
      step();
      check_a("fl.pre", 1'b1, 2'd2, 1'b0, AW'('h1A));
      a_flush = 1'b1; a_in_payload = AW'('hC);
      step();
      check_a("fl.post", 1'b0, 2'd0, 1'b1, '0);
      check("fl.payload", a_out_payload, 0);
      check("fl.stall",   a_stall, 4);
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      step();
      check_a("fl.noC", 1'b0, 2'd0, 1'b1, '0);
      check("fl.noC.payload", a_out_payload, 0);

      // 5. Stall counter saturates at 15 and survives flush.
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_payload = AW'('h55);
      step();
      a_in_valid = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check("sat.value", a_stall, 15);
      check_a("sat.held", 1'b1, 2'd1, 1'b1, AW'('h55));
      a_flush = 1'b1;
      step();
      a_flush = 1'b0;
      check("sat.flush", a_stall, 15);
      check_a("sat.flushed", 1'b0, 2'd0, 1'b1, '0);

      // 6. Reset mid-operation with two held beats.
      a_in_valid = 1'b1; a_in_payload = AW'('h61);
      step();
      a_in_payload = AW'('h62);
      step();
      check_a("rm.pre", 1'b1, 2'd2, 1'b0, AW'('h61));
      a_in_valid = 1'b0; rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_a("rm.post", 1'b0, 2'd0, 1'b1, '0);
      check("rm.payload", a_out_payload, 0);
      check("rm.stall",   a_stall, 0);
      a_out_ready = 1'b1;
      step();
      check_a("rm.lost", 1'b0, 2'd0, 1'b1, '0);

      // 4. Bubble on the single-register stage.
      b_out_ready = 1'b1; b_in_valid = 1'b1; b_in_payload = 8'h05;
      #1;
      check("bub.ready_empty", b_in_ready, 1);
      step();
      check("bub.valid", b_out_valid, 1);
      check("bub.payload", b_out_payload, 8'h05);
      b_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("bub.gap%0d", i), b_out_valid, 0);
         check($sformatf("bub.occ%0d", i), b_occ, 0);
      end

      // Single-register backpressure: ready follows out_ready combinationally.
      b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_payload = 8'h11;
      step();
      check("b.full.valid", b_out_valid, 1);
      check("b.full.ready", b_in_ready, 0);
      b_in_payload = 8'h33;               // not accepted: stage full, stalled
      step();
      check("b.hold.payload", b_out_payload, 8'h11);
      check("b.stall", b_stall, 1);
      b_out_ready = 1'b1; b_in_payload = 8'h22;
      #1;
      check("b.comb.ready", b_in_ready, 1);
      step();                             // 0x11 out, 0x22 in on the same edge
      check("b.swap.payload", b_out_payload, 8'h22);
      check("b.swap.occ", b_occ, 1);

      // Flush with CLEAR_ON_FLUSH=0: valid drops, stale payload stays.
      b_in_valid = 1'b0; b_out_ready = 1'b0; b_flush = 1'b1;
      step();
      b_flush = 1'b0;
      check("b.flush.valid", b_out_valid, 0);
      check("b.flush.payload", b_out_payload, 8'h22);
      check("b.flush.ready", b_in_ready, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
